// File: rtl/stack_pkg.sv
// Shared types and default sizes for the stack controller.
// Opcode and FSM state encodings used by the controller and its ALU.
package stack_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_SEL_W  = $clog2(DEF_DEPTH);

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_DUP  = 3'd3,
        OP_SWAP = 3'd4,
        OP_ADD  = 3'd5,
        OP_SUB  = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

endpackage

// File: rtl/stack_ctrl_if.sv
// Opcode/response handshake bundle and the register-file port bundle.
// The controller is the slave of the op bundle and the master of the regfile.
interface stack_op_if
    import stack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              op_valid;
    logic              op_ready;
    logic [2:0]        op_code;
    logic [DATA_W-1:0] op_imm;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    modport master (
        output op_valid, op_code, op_imm,
        input  op_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  op_valid, op_code, op_imm,
        output op_ready, resp_valid, resp_data, resp_err
    );
endinterface

interface stack_rf_if
    import stack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W  = DEF_SEL_W
);
    logic [SEL_W-1:0]  re_sel_a;
    logic [SEL_W-1:0]  re_sel_b;
    logic [DATA_W-1:0] re_data_a;
    logic [DATA_W-1:0] re_data_b;
    logic [SEL_W-1:0]  wr_sel_a;
    logic [SEL_W-1:0]  wr_sel_b;
    logic [DATA_W-1:0] wr_data_a;
    logic [DATA_W-1:0] wr_data_b;
    logic              wr_en_a;
    logic              wr_en_b;

    modport master (
        output re_sel_a, re_sel_b,
        input  re_data_a, re_data_b,
        output wr_sel_a, wr_sel_b, wr_data_a, wr_data_b,
        output wr_en_a, wr_en_b
    );

    modport slave (
        input  re_sel_a, re_sel_b,
        output re_data_a, re_data_b,
        input  wr_sel_a, wr_sel_b, wr_data_a, wr_data_b,
        input  wr_en_a, wr_en_b
    );
endinterface

// File: rtl/stack_alu.sv
// Combinational add/subtract for the stack controller writeback path.
// carry_o is the carry-out for ADD and the borrow (N < T) for SUB.
module stack_alu
    import stack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  op_e               op_i,
    input  logic [DATA_W-1:0] n_i,
    input  logic [DATA_W-1:0] t_i,
    output logic [DATA_W-1:0] res_o,
    output logic              carry_o,
    output logic              zero_o
);
    logic [DATA_W:0] wide;

    always_comb begin
        wide = '0;
        unique case (op_i)
            OP_ADD:  wide = {1'b0, n_i} + {1'b0, t_i};
            OP_SUB:  wide = {1'b0, n_i} - {1'b0, t_i};
            default: wide = '0;
        endcase
    end

    assign res_o   = wide[DATA_W-1:0];
    assign carry_o = wide[DATA_W];
    assign zero_o  = (res_o == '0);

endmodule

// File: rtl/stack_ctrl.sv
// LIFO front end for a 2R/2W register file: IDLE -> EXEC -> WB per op.
// Define STACK_CTRL_FLAGS_EN to register zero/carry flags on ADD/SUB.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  logic           clock,
    input  logic           reset,
    stack_op_if.slave      op,
    stack_rf_if.master     rf,
    output logic [SEL_W:0] depth,
    output logic           err_sticky,
    output logic           flag_z,
    output logic           flag_c
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_EXEC = EXEC;
    localparam logic [1:0] ST_WB   = WB;

    localparam logic [SEL_W:0]   FULL = (SEL_W+1)'(DEPTH);
    localparam logic [SEL_W:0]   TWO  = (SEL_W+1)'(2);
    localparam logic [SEL_W:0]   ONE  = (SEL_W+1)'(1);
    localparam logic [SEL_W-1:0] S1   = SEL_W'(1);
    localparam logic [SEL_W-1:0] S2   = SEL_W'(2);

    logic [1:0]        state_q, state_d;
    op_e               op_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] tos_q;
    logic [DATA_W-1:0] nos_q;
    logic              err_q, err_d;
    logic [SEL_W:0]    depth_q, depth_d;
    logic              sticky_q;

    logic              in_exec, in_wb, accept;
    logic [SEL_W-1:0]  sel_d0, sel_m1, sel_m2;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry, alu_zero;
    logic              wa_en, wb_en;
    logic [SEL_W-1:0]  wa_sel, wb_sel;
    logic [DATA_W-1:0] wa_data, wb_data, rdata;

    assign in_exec     = (state_q == ST_EXEC);
    assign in_wb       = (state_q == ST_WB);
    assign op.op_ready = (state_q == ST_IDLE);
    assign accept      = op.op_valid && op.op_ready;

    // Slot indices wrap modulo DEPTH through SEL_W truncation.
    assign sel_d0 = depth_q[SEL_W-1:0];
    assign sel_m1 = sel_d0 - S1;
    assign sel_m2 = sel_d0 - S2;

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            (state_q == ST_IDLE): if (accept) state_d = ST_EXEC;
            in_exec:              state_d = ST_WB;
            in_wb:                state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        err_d = 1'b0;
        unique case (op_q)
            OP_PUSH: err_d = (depth_q == FULL);
            OP_POP:  err_d = (depth_q == '0);
            OP_DUP:  err_d = (depth_q == FULL) || (depth_q == '0);
            OP_SWAP,
            OP_ADD,
            OP_SUB:  err_d = (depth_q < TWO);
            default: err_d = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_NOP;
            imm_q    <= '0;
            tos_q    <= '0;
            nos_q    <= '0;
            err_q    <= 1'b0;
            depth_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= op_e'(op.op_code);
                imm_q <= op.op_imm;
            end
            if (in_exec) begin
                tos_q <= rf.re_data_a;
                nos_q <= rf.re_data_b;
                err_q <= err_d;
            end
            if (in_wb) begin
                depth_q  <= depth_d;
                sticky_q <= sticky_q | err_q;
            end
        end
    end

    stack_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i    (op_q),
        .n_i     (nos_q),
        .t_i     (tos_q),
        .res_o   (alu_res),
        .carry_o (alu_carry),
        .zero_o  (alu_zero)
    );

    always_comb begin
        wa_en   = 1'b0;
        wb_en   = 1'b0;
        wa_sel  = '0;
        wb_sel  = '0;
        wa_data = '0;
        wb_data = '0;
        rdata   = '0;
        depth_d = depth_q;
        if (in_wb && !err_q) begin
            unique case (op_q)
                OP_PUSH: begin
                    wa_en   = 1'b1;
                    wa_sel  = sel_d0;
                    wa_data = imm_q;
                    rdata   = imm_q;
                    depth_d = depth_q + ONE;
                end
                OP_POP: begin
                    rdata   = tos_q;
                    depth_d = depth_q - ONE;
                end
                OP_DUP: begin
                    wa_en   = 1'b1;
                    wa_sel  = sel_d0;
                    wa_data = tos_q;
                    rdata   = tos_q;
                    depth_d = depth_q + ONE;
                end
                OP_SWAP: begin
                    wa_en   = 1'b1;
                    wa_sel  = sel_m1;
                    wa_data = nos_q;
                    wb_en   = 1'b1;
                    wb_sel  = sel_m2;
                    wb_data = tos_q;
                    rdata   = nos_q;
                end
                OP_ADD,
                OP_SUB: begin
                    wa_en   = 1'b1;
                    wa_sel  = sel_m2;
                    wa_data = alu_res;
                    rdata   = alu_res;
                    depth_d = depth_q - ONE;
                end
                default: rdata = (depth_q != '0) ? tos_q : '0;
            endcase
        end
    end

    // Reset in the WB cycle must still suppress the commit and the strobe.
    assign rf.re_sel_a  = in_exec ? sel_m1 : '0;
    assign rf.re_sel_b  = in_exec ? sel_m2 : '0;
    assign rf.wr_en_a   = wa_en & ~reset;
    assign rf.wr_en_b   = wb_en & ~reset;
    assign rf.wr_sel_a  = wa_sel;
    assign rf.wr_sel_b  = wb_sel;
    assign rf.wr_data_a = wa_data;
    assign rf.wr_data_b = wb_data;

    assign op.resp_valid = in_wb & ~reset;
    assign op.resp_err   = in_wb & err_q & ~reset;
    assign op.resp_data  = rdata;

    assign depth      = depth_q;
    assign err_sticky = sticky_q;

`ifdef STACK_CTRL_FLAGS_EN
    logic fz_q, fc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            fz_q <= 1'b0;
            fc_q <= 1'b0;
        end else if (in_wb && !err_q &&
                     (op_q == OP_ADD || op_q == OP_SUB)) begin
            fz_q <= alu_zero;
            fc_q <= alu_carry;
        end
    end

    assign flag_z = fz_q;
    assign flag_c = fc_q;
`else
    logic unused_flags;
    assign unused_flags = alu_zero ^ alu_carry;
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: directed vector table, reset-abort sequence,
// then random ops against a queue-based stack model.
module tb_stack_ctrl;
    import stack_pkg::*;

`ifdef STACK_CTRL_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] depth;
    logic       err_sticky, flag_z, flag_c;

    stack_op_if #(.DATA_W(8)) op_if ();
    stack_rf_if #(.DATA_W(8), .SEL_W(3)) rf_if ();

    stack_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .op         (op_if),
        .rf         (rf_if),
        .depth      (depth),
        .err_sticky (err_sticky),
        .flag_z     (flag_z),
        .flag_c     (flag_c)
    );

    always #5 clock = ~clock;

    // Register file stand-in: combinational reads, edge-committed writes.
    logic [7:0] mem [8];
    int wr_cnt = 0;
    int resp_cnt = 0;

    assign rf_if.re_data_a = mem[rf_if.re_sel_a];
    assign rf_if.re_data_b = mem[rf_if.re_sel_b];

    always @(posedge clock) begin
        if (rf_if.wr_en_a) mem[rf_if.wr_sel_a] <= rf_if.wr_data_a;
        if (rf_if.wr_en_b) mem[rf_if.wr_sel_b] <= rf_if.wr_data_b;
        wr_cnt <= wr_cnt + int'(rf_if.wr_en_a) + int'(rf_if.wr_en_b);
        resp_cnt <= resp_cnt + int'(op_if.resp_valid);
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference stack: element i lives in register i.
    logic [7:0] q[$];
    bit m_sticky = 1'b0;
    bit m_fz = 1'b0;
    bit m_fc = 1'b0;

    function automatic void model_step(input logic [2:0] code,
                                       input logic [7:0] imm,
                                       output logic [7:0] ed,
                                       output bit ee);
        int sz = q.size();
        int n, t, r;
        ed = 8'h00;
        ee = 1'b0;
        case (code)
            3'd1: if (sz == 8) ee = 1'b1;
                  else begin q.push_back(imm); ed = imm; end
            3'd2: if (sz == 0) ee = 1'b1;
                  else ed = q.pop_back();
            3'd3: if (sz == 0 || sz == 8) ee = 1'b1;
                  else begin ed = q[sz-1]; q.push_back(ed); end
            3'd4: if (sz < 2) ee = 1'b1;
                  else begin
                      t = int'(q[sz-1]);
                      n = int'(q[sz-2]);
                      q[sz-1] = 8'(n);
                      q[sz-2] = 8'(t);
                      ed = 8'(n);
                  end
            3'd5, 3'd6: if (sz < 2) ee = 1'b1;
                  else begin
                      t = int'(q.pop_back());
                      n = int'(q.pop_back());
                      r = (code == 3'd5) ? n + t : n - t;
                      ed = 8'(r);
                      q.push_back(ed);
                      if (FLAGS_ON) begin
                          m_fz = (ed == 8'h00);
                          m_fc = (code == 3'd5) ? (r > 255) : (n < t);
                      end
                  end
            default: ed = (sz > 0) ? q[sz-1] : 8'h00;
        endcase
        if (ee) m_sticky = 1'b1;
    endfunction

    logic [7:0] a_data;
    logic       a_err;

    // Drives one op at a negedge and returns at the negedge after WB.
    task automatic do_op(input logic [2:0] code, input logic [7:0] imm,
                         input bit junk);
        int k = 0;
        while (op_if.op_ready !== 1'b1 && k < 10) begin
            @(negedge clock);
            k++;
        end
        check("ready_wait", 32'(op_if.op_ready), 32'd1);
        op_if.op_valid = 1'b1;
        op_if.op_code  = code;
        op_if.op_imm   = imm;
        @(negedge clock);
        check("lat_exec_valid", 32'(op_if.resp_valid), 32'd0);
        check("busy_ready", 32'(op_if.op_ready), 32'd0);
        op_if.op_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        op_if.op_code  = 3'($urandom_range(0, 7));
        op_if.op_imm   = 8'($urandom_range(0, 255));
        @(negedge clock);
        check("lat_wb_valid", 32'(op_if.resp_valid), 32'd1);
        a_data = op_if.resp_data;
        a_err  = op_if.resp_err;
        if (rf_if.wr_en_a && rf_if.wr_en_b)
            check("sel_clash", 32'(rf_if.wr_sel_a != rf_if.wr_sel_b), 32'd1);
        if (a_err)
            check("err_nowrite", 32'({rf_if.wr_en_a, rf_if.wr_en_b}), 32'd0);
        op_if.op_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clock);
        op_if.op_valid = 1'b0;
        check("resp_one_cycle", 32'(op_if.resp_valid), 32'd0);
    endtask

    task automatic check_state();
        check("depth_model", 32'(depth), 32'(q.size()));
        check("sticky_model", 32'(err_sticky), 32'(m_sticky));
        check("flag_z_model", 32'(flag_z), 32'(m_fz));
        check("flag_c_model", 32'(flag_c), 32'(m_fc));
        for (int i = 0; i < q.size(); i++)
            check($sformatf("mem%0d", i), 32'(mem[i]), 32'(q[i]));
    endtask

    typedef struct {
        logic [2:0] code;
        logic [7:0] imm;
        logic [7:0] data;
        bit         err;
        int         dep;
        bit         fz;
        bit         fc;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [2:0] c, input logic [7:0] i,
                                input logic [7:0] d, input bit e,
                                input int dp, input bit z, input bit cy);
        vec_t v;
        v.code = c; v.imm = i; v.data = d; v.err = e;
        v.dep = dp; v.fz = z; v.fc = cy;
        tbl.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] ed;
        bit         ee;
        int         w0, r0;

        add(3'd1, 8'h05, 8'h05, 0, 1, 0, 0);
        add(3'd1, 8'h03, 8'h03, 0, 2, 0, 0);
        add(3'd5, 8'h00, 8'h08, 0, 1, 0, 0);
        add(3'd2, 8'h00, 8'h08, 0, 0, 0, 0);
        add(3'd0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(3'd1, 8'h10, 8'h10, 0, 1, 0, 0);
        add(3'd1, 8'h20, 8'h20, 0, 2, 0, 0);
        add(3'd4, 8'h00, 8'h10, 0, 2, 0, 0);
        add(3'd2, 8'h00, 8'h10, 0, 1, 0, 0);
        add(3'd2, 8'h00, 8'h20, 0, 0, 0, 0);
        add(3'd2, 8'h00, 8'h00, 1, 0, 0, 0);
        add(3'd3, 8'h00, 8'h00, 1, 0, 0, 0);
        for (int i = 1; i <= 8; i++)
            add(3'd1, 8'(i), 8'(i), 0, i, 0, 0);
        add(3'd1, 8'h09, 8'h00, 1, 8, 0, 0);
        add(3'd3, 8'h00, 8'h00, 1, 8, 0, 0);
        for (int i = 8; i >= 1; i--)
            add(3'd2, 8'h00, 8'(i), 0, i - 1, 0, 0);
        add(3'd1, 8'h02, 8'h02, 0, 1, 0, 0);
        add(3'd4, 8'h00, 8'h00, 1, 1, 0, 0);
        add(3'd1, 8'h05, 8'h05, 0, 2, 0, 0);
        add(3'd6, 8'h00, 8'hFD, 0, 1, 0, 1);
        add(3'd3, 8'h00, 8'hFD, 0, 2, 0, 1);
        add(3'd0, 8'h00, 8'hFD, 0, 2, 0, 1);
        add(3'd7, 8'h00, 8'hFD, 0, 2, 0, 1);
        add(3'd5, 8'h00, 8'hFA, 0, 1, 0, 1);

        op_if.op_valid = 1'b0;
        op_if.op_code  = 3'd0;
        op_if.op_imm   = 8'h00;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        check("rst_ready", 32'(op_if.op_ready), 32'd1);
        check("rst_depth", 32'(depth), 32'd0);
        check("rst_resp_valid", 32'(op_if.resp_valid), 32'd0);
        check("rst_resp_data", 32'(op_if.resp_data), 32'd0);
        check("rst_resp_err", 32'(op_if.resp_err), 32'd0);
        check("rst_sticky", 32'(err_sticky), 32'd0);
        check("rst_flags", 32'({flag_z, flag_c}), 32'd0);
        check("rst_wr_en", 32'({rf_if.wr_en_a, rf_if.wr_en_b}), 32'd0);
        check("rst_sels", 32'({rf_if.re_sel_a, rf_if.re_sel_b,
                                rf_if.wr_sel_a, rf_if.wr_sel_b}), 32'd0);

        foreach (tbl[i]) begin
            do_op(tbl[i].code, tbl[i].imm, 1'b0);
            model_step(tbl[i].code, tbl[i].imm, ed, ee);
            check($sformatf("vec%0d_data", i), 32'(a_data), 32'(tbl[i].data));
            check($sformatf("vec%0d_err", i), 32'(a_err), 32'(tbl[i].err));
            check($sformatf("vec%0d_depth", i), 32'(depth), 32'(tbl[i].dep));
            check($sformatf("vec%0d_flags", i), 32'({flag_z, flag_c}),
                  FLAGS_ON ? 32'({tbl[i].fz, tbl[i].fc}) : 32'd0);
            check_state();
        end

        // Reset while a PUSH sits in EXEC.
        w0 = wr_cnt;
        r0 = resp_cnt;
        op_if.op_valid = 1'b1;
        op_if.op_code  = 3'd1;
        op_if.op_imm   = 8'hAA;
        @(negedge clock);
        op_if.op_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_ready", 32'(op_if.op_ready), 32'd1);
        @(negedge clock);
        @(negedge clock);
        check("abort_no_write", 32'(wr_cnt), 32'(w0));
        check("abort_no_resp", 32'(resp_cnt), 32'(r0));
        check("abort_depth", 32'(depth), 32'd0);
        check("abort_sticky", 32'(err_sticky), 32'd0);
        check("abort_flags", 32'({flag_z, flag_c}), 32'd0);
        q.delete();
        m_sticky = 1'b0;
        m_fz = 1'b0;
        m_fc = 1'b0;

        for (int n = 0; n < 250; n++) begin
            logic [2:0] c;
            logic [7:0] im;
            c  = 3'($urandom_range(0, 7));
            im = 8'($urandom_range(0, 255));
            do_op(c, im, 1'b1);
            model_step(c, im, ed, ee);
            check($sformatf("rnd%0d_data", n), 32'(a_data), 32'(ed));
            check($sformatf("rnd%0d_err", n), 32'(a_err), 32'(ee));
            check_state();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
